// File: rtl/crg_uart_pkg.sv
// Shared UART types and constants for the CRG board link.
// Used by both the frame transmitter and the host-command receiver.
package crg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } tx_state_t;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;

  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/crg_uart_frame_tx_if.sv
// Request/status bundle of the CRG frame transmitter.
// master: start, dout_data out; slave: busy, done, uart_tx out.
interface crg_uart_frame_tx_if #(
  parameter int len_dout = 768
);

  logic                start;
  logic [len_dout-1:0] dout_data;
  logic                busy;
  logic                done;
  logic                uart_tx;

  modport master (
    output start,
    output dout_data,
    input  busy,
    input  done,
    input  uart_tx
  );

  modport slave (
    input  start,
    input  dout_data,
    output busy,
    output done,
    output uart_tx
  );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with its bit-period counter.
// Ports: clk, rst, valid/data in, ready out (idle or last stop cycle), tx.
module uart_tx_byte
  import crg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        last;

  assign last = (cnt_q == LAST);
  assign tx   = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= UART_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        ready = 1'b1;
        tx_d  = UART_IDLE;
        if (valid) begin
          state_d = START_BIT;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA_BIT;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end
      end
      DATA_BIT: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = UART_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      STOP_BIT: begin
        // Next byte is taken in the final stop cycle: no gap.
        ready = last;
        if (last) begin
          cnt_d = '0;
          if (valid) begin
            state_d = START_BIT;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = UART_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/crg_uart_frame_tx.sv
// Serializes one len_dout-bit result word as 8N1 bytes, LSB byte first.
// Ports: clk, rst (sync, active-high), bus (slave: start/dout_data in; busy/done/uart_tx out).
module crg_uart_frame_tx
  import crg_uart_pkg::*;
#(
  parameter int len_dout     = 768,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  crg_uart_frame_tx_if.slave bus
);

  localparam int NB   = len_dout / 8;
  localparam int CNTW = $clog2(NB + 1);

  if (len_dout % 8 != 0 || len_dout < 8) begin : g_len_chk
    $error("len_dout must be a positive multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be at least 2");
  end

  logic [len_dout-1:0] sh_q, sh_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                b_valid;
  logic                b_ready;
  logic [7:0]          b_data;
  logic                b_tx;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .valid(b_valid),
    .data (b_data),
    .ready(b_ready),
    .tx   (b_tx)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.uart_tx = b_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // cnt_q counts bytes already handed to the serializer.
  // Byte 0 goes straight from dout_data so the start bit
  // follows the accepting edge with no extra register stage.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    b_valid = 1'b0;
    b_data  = sh_q[7:0];
    if (!busy_q) begin
      b_valid = bus.start;
      b_data  = bus.dout_data[7:0];
      if (bus.start && b_ready) begin
        sh_d   = bus.dout_data >> 8;
        cnt_d  = CNTW'(1);
        busy_d = 1'b1;
      end
    end else begin
      b_valid = (cnt_q != CNTW'(NB));
      if (b_ready) begin
        if (b_valid) begin
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          cnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crg_uart_frame_tx.sv
// Self-checking bench for crg_uart_frame_tx (len_dout=16, CLKS_PER_BIT=4).
// Frame-level model, line decoder and directed literal checks.
module tb_crg_uart_frame_tx;

  localparam int LEN = 16;
  localparam int CPB = 4;
  localparam int NB  = LEN / 8;
  localparam int F   = NB * 10 * CPB;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  crg_uart_frame_tx_if #(.len_dout(LEN)) bus ();

  crg_uart_frame_tx #(
    .len_dout    (LEN),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Frame model: offset t from the first cycle after acceptance.
  bit          m_act = 0;
  int          m_t   = 0;
  logic [LEN-1:0] m_d = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0;
    end else if (m_act && m_t < F) begin
      m_t++;
    end else if (bus.start === 1'b1) begin
      m_act = 1;
      m_t   = 0;
      m_d   = bus.dout_data;
    end else begin
      m_act = 0;
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_busy, e_done;
    int k, j;
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (m_act && m_t == F) begin
      e_done = 1'b1;
    end else if (m_act) begin
      e_busy = 1'b1;
      k = m_t / (10 * CPB);
      j = (m_t % (10 * CPB)) / CPB;
      if (j == 0) e_tx = 1'b0;
      else if (j == 9) e_tx = 1'b1;
      else e_tx = m_d[8*k + j - 1];
    end
    if (chk_en) begin
      chk("model_tx", 32'(bus.uart_tx), 32'(e_tx));
      chk("model_busy", 32'(bus.busy), 32'(e_busy));
      chk("model_done", 32'(bus.done), 32'(e_done));
    end
  end

  // Line decoder: samples mid-bit, drops a byte cut by reset.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         inb = 0;
  int         rc  = 0;
  logic [7:0] rsh = '0;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      inb = 0;
    end else if (!inb) begin
      if (bus.uart_tx === 1'b0) begin
        inb = 1;
        rc  = 0;
      end
    end else begin
      rc++;
      if (rc == CPB/2) chk("rx_start", 32'(bus.uart_tx), 32'd0);
      for (int b = 1; b <= 8; b++)
        if (rc == b*CPB + CPB/2) rsh[b-1] = bus.uart_tx;
      if (rc == 9*CPB + CPB/2) begin
        chk("rx_stop", 32'(bus.uart_tx), 32'd1);
        rx_q.push_back(rsh);
        inb = 0;
      end
    end
  end

  int busy_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns one cycle into the frame: t = 0.
  task automatic send(input logic [LEN-1:0] d);
    step();
    bus.start     = 1'b1;
    bus.dout_data = d;
    step();
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [LEN-1:0] d);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  task automatic check_bytes(input string nm);
    chk({nm, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({nm, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  int b0, d0;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dout_data = '0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_tx", 32'(bus.uart_tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (10) step();
    check_bytes("idle");

    // Single frame A55A
    b0 = busy_cnt; d0 = done_cnt;
    send(16'hA55A);
    push_exp(16'hA55A);
    chk("sf_t0_tx", 32'(bus.uart_tx), 32'd0);
    chk("sf_t0_busy", 32'(bus.busy), 32'd1);
    for (int t = 1; t <= 90; t++) begin
      step();
      case (t)
        4:  chk("sf_b0_bit0", 32'(bus.uart_tx), 32'd0);
        8:  chk("sf_b0_bit1", 32'(bus.uart_tx), 32'd1);
        36: chk("sf_b0_stop", 32'(bus.uart_tx), 32'd1);
        40: chk("sf_b1_start", 32'(bus.uart_tx), 32'd0);
        44: chk("sf_b1_bit0", 32'(bus.uart_tx), 32'd1);
        48: chk("sf_b1_bit1", 32'(bus.uart_tx), 32'd0);
        79: chk("sf_t79_busy", 32'(bus.busy), 32'd1);
        80: begin
          chk("sf_done", 32'(bus.done), 32'd1);
          chk("sf_done_busy", 32'(bus.busy), 32'd0);
        end
        81: chk("sf_done_pulse", 32'(bus.done), 32'd0);
        default: ;
      endcase
    end
    chk("sf_busy_cycles", 32'(busy_cnt - b0), 32'd80);
    chk("sf_done_count", 32'(done_cnt - d0), 32'd1);
    check_bytes("sf");

    // Start while busy, data changed after acceptance
    d0 = done_cnt;
    send(16'hA55A);
    push_exp(16'hA55A);
    for (int t = 1; t <= 95; t++) begin
      step();
      if (t == 20) begin
        bus.start     = 1'b1;
        bus.dout_data = 16'hFFFF;
      end
      if (t == 21) bus.start = 1'b0;
    end
    chk("swb_done_count", 32'(done_cnt - d0), 32'd1);
    check_bytes("swb");

    // Back-to-back: start in the done cycle
    d0 = done_cnt;
    send(16'hA55A);
    push_exp(16'hA55A);
    for (int t = 1; t <= 81; t++) begin
      step();
      if (t == 80) begin
        chk("b2b_done", 32'(bus.done), 32'd1);
        bus.start     = 1'b1;
        bus.dout_data = 16'h00FF;
      end
      if (t == 81) begin
        bus.start = 1'b0;
        chk("b2b_next_start", 32'(bus.uart_tx), 32'd0);
        chk("b2b_next_busy", 32'(bus.busy), 32'd1);
      end
    end
    push_exp(16'h00FF);
    repeat (90) step();
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check_bytes("b2b");

    // Reset during byte 1 data bits
    d0 = done_cnt;
    send(16'hA55A);
    exp_q.push_back(8'h5A);
    for (int t = 1; t <= 52; t++) begin
      step();
      if (t == 50) begin
        chk("mr_pre_tx", 32'(bus.uart_tx), 32'd0);
        rst = 1'b1;
      end
      if (t == 51) begin
        chk("mr_tx", 32'(bus.uart_tx), 32'd1);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
      end
    end
    repeat (60) step();
    chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
    check_bytes("mr");
    send(16'h1234);
    push_exp(16'h1234);
    repeat (90) step();
    chk("mr_after_done", 32'(done_cnt - d0), 32'd1);
    check_bytes("mr_after");

    // Random words
    for (int i = 0; i < 4; i++) begin
      logic [LEN-1:0] r;
      r = LEN'($urandom_range(0, 65535));
      send(r);
      push_exp(r);
      repeat (90) step();
      check_bytes("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
